// File: rtl/uart_defs.sv
// Shared UART definitions: baud encodings, oversampling constants and receiver FSM states.
// Intended to be reused by the transmit side of the link as well.
package uart_defs;

    localparam int unsigned OSR = 16;

    localparam logic [3:0] SAMPLE_A  = 4'd7;
    localparam logic [3:0] SAMPLE_B  = 4'd8;
    localparam logic [3:0] SAMPLE_C  = 4'd9;
    localparam logic [3:0] LAST_TICK = 4'd15;

    typedef enum logic [2:0] {
        BAUD_9600   = 3'd0,
        BAUD_19200  = 3'd1,
        BAUD_38400  = 3'd2,
        BAUD_57600  = 3'd3,
        BAUD_115200 = 3'd4
    } baud_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_e;

    // Clocks per 16x tick, truncated.
    function automatic int unsigned tick_period(input int unsigned clk_freq, input int unsigned baud);
        return clk_freq / (OSR * baud);
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// 16x oversampling tick generator; period chosen from a latched baud select.
// clr_i restarts the count so the first tick lands one full period after the start edge.
module uart_baud_tick
    import uart_defs::*;
#(
    parameter int unsigned CLK_FREQ = 50_000_000
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       clr_i,
    input  logic [2:0] baud_sel_i,
    output logic       tick_o
);

    localparam int unsigned P0 = tick_period(CLK_FREQ, 9600);
    localparam int unsigned P1 = tick_period(CLK_FREQ, 19200);
    localparam int unsigned P2 = tick_period(CLK_FREQ, 38400);
    localparam int unsigned P3 = tick_period(CLK_FREQ, 57600);
    localparam int unsigned P4 = tick_period(CLK_FREQ, 115200);
    localparam int          CW = $clog2(P0 + 1);

    logic [CW-1:0] cnt_q, cnt_d, period_m1;

    // Constant table rather than a divider: only five rates exist.
    always_comb begin
        period_m1 = CW'(P0 - 1);
        case (baud_sel_i)
            BAUD_19200:  period_m1 = CW'(P1 - 1);
            BAUD_38400:  period_m1 = CW'(P2 - 1);
            BAUD_57600:  period_m1 = CW'(P3 - 1);
            BAUD_115200: period_m1 = CW'(P4 - 1);
            default:     period_m1 = CW'(P0 - 1);
        endcase
    end

    assign tick_o = (cnt_q == period_m1);

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clr_i || tick_o) cnt_d = '0;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver: synchronised line, 3-sample majority vote per bit, LSB-first byte
// delivered with a one-cycle Rx_Done strobe; a bad stop bit gives a frame_err strobe.
module uart_byte_rx
    import uart_defs::*;
#(
    parameter int unsigned CLK_FREQ = 50_000_000
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Rs232_Rx,
    input  logic [2:0] baud_set,
    output logic [7:0] data_byte,
    output logic       Rx_Done,
    output logic       frame_err,
    output logic       uart_state
);

    logic [1:0] sync_q;
    logic       prev_q;
    logic       rx_s, start_edge, tick, tick_clr, vote;
    state_e     state_q, state_d;
    logic [2:0] baud_q, baud_d;
    logic [3:0] tick_idx_q, tick_idx_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic [1:0] samp_q, samp_d;
    logic [7:0] shift_q, shift_d, data_q, data_d;
    logic       done_q, done_d, ferr_q, ferr_d;

    assign rx_s       = sync_q[1];
    assign start_edge = prev_q & ~rx_s;

    uart_baud_tick #(.CLK_FREQ(CLK_FREQ)) u_tick (
        .Clk        (Clk),
        .Rst        (Rst),
        .clr_i      (tick_clr),
        .baud_sel_i (baud_q),
        .tick_o     (tick)
    );

    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        tick_idx_d = tick_idx_q;
        bit_idx_d  = bit_idx_q;
        samp_d     = samp_q;
        shift_d    = shift_q;
        data_d     = data_q;
        done_d     = 1'b0;
        ferr_d     = 1'b0;
        tick_clr   = 1'b0;
        vote       = maj3(samp_q[0], samp_q[1], rx_s);

        if (state_q == ST_IDLE) begin
            if (start_edge) begin
                state_d    = ST_START;
                baud_d     = baud_set;
                tick_clr   = 1'b1;
                tick_idx_d = '0;
                bit_idx_d  = '0;
            end
        end else if (tick) begin
            tick_idx_d = tick_idx_q + 4'd1;
            if (tick_idx_q == SAMPLE_A) samp_d[0] = rx_s;
            if (tick_idx_q == SAMPLE_B) samp_d[1] = rx_s;
            case (state_q)
                ST_START: begin
                    if (tick_idx_q == SAMPLE_C && vote)  state_d = ST_IDLE;
                    else if (tick_idx_q == LAST_TICK)    state_d = ST_DATA;
                end
                ST_DATA: begin
                    if (tick_idx_q == SAMPLE_C) begin
                        shift_d = {vote, shift_q[7:1]};
                    end else if (tick_idx_q == LAST_TICK) begin
                        if (bit_idx_q == 3'd7) state_d = ST_STOP;
                        else                   bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
                ST_STOP: begin
                    // Leave at mid-stop so a back-to-back start edge is not missed.
                    if (tick_idx_q == SAMPLE_C) begin
                        state_d = ST_IDLE;
                        if (vote) begin
                            data_d = shift_q;
                            done_d = 1'b1;
                        end else begin
                            ferr_d = 1'b1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Line flops reset high so releasing reset never looks like a start edge.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            sync_q     <= 2'b11;
            prev_q     <= 1'b1;
            state_q    <= ST_IDLE;
            baud_q     <= '0;
            tick_idx_q <= '0;
            bit_idx_q  <= '0;
            samp_q     <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            done_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], Rs232_Rx};
            prev_q     <= rx_s;
            state_q    <= state_d;
            baud_q     <= baud_d;
            tick_idx_q <= tick_idx_d;
            bit_idx_q  <= bit_idx_d;
            samp_q     <= samp_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            done_q     <= done_d;
            ferr_q     <= ferr_d;
        end
    end

    assign data_byte  = data_q;
    assign Rx_Done    = done_q;
    assign frame_err  = ferr_q;
    assign uart_state = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_byte_rx.sv
// Directed bench for uart_byte_rx at 50 MHz: good frames, back-to-back, glitches,
// framing error, asynchronous reset mid-frame and a mid-frame baud_set change.
`timescale 1ns/1ps
module tb_uart_byte_rx;

    localparam int BIT115 = 432;
    localparam int BIT9600 = 5200;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       Rs232_Rx = 1'b1;
    logic [2:0] baud_set = 3'd4;
    logic [7:0] data_byte;
    logic       Rx_Done, frame_err, uart_state;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int ferr_cnt = 0;
    int busy_cnt = 0;
    int both_cnt = 0;
    logic [7:0] rx_log[$];
    int d0, f0, b0;

    always #5 Clk = ~Clk;

    uart_byte_rx #(.CLK_FREQ(50_000_000)) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .Rs232_Rx   (Rs232_Rx),
        .baud_set   (baud_set),
        .data_byte  (data_byte),
        .Rx_Done    (Rx_Done),
        .frame_err  (frame_err),
        .uart_state (uart_state)
    );

    always @(negedge Clk) begin
        if (Rx_Done) begin
            done_cnt <= done_cnt + 1;
            rx_log.push_back(data_byte);
        end
        if (frame_err)             ferr_cnt <= ferr_cnt + 1;
        if (uart_state)            busy_cnt <= busy_cnt + 1;
        if (Rx_Done && frame_err)  both_cnt <= both_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Drives one 8N1 frame from a negedge; optional 1-Clk spike or baud change mid data bit.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int cyc,
                              input int spike_bit, input int chg_bit);
        Rs232_Rx = 1'b0;
        repeat (cyc) @(negedge Clk);
        for (int b = 0; b < 8; b++) begin
            Rs232_Rx = d[b];
            if (b == spike_bit || b == chg_bit) begin
                repeat (cyc / 2) @(negedge Clk);
                if (b == spike_bit) Rs232_Rx = ~d[b];
                if (b == chg_bit)   baud_set = 3'd4;
                @(negedge Clk);
                Rs232_Rx = d[b];
                repeat (cyc - cyc / 2 - 1) @(negedge Clk);
            end else begin
                repeat (cyc) @(negedge Clk);
            end
        end
        Rs232_Rx = stop;
        repeat (cyc) @(negedge Clk);
        Rs232_Rx = 1'b1;
    endtask

    initial begin
        repeat (3) @(negedge Clk);
        chk("rst_data", 32'(data_byte), 32'h00);
        chk("rst_done", 32'(Rx_Done), 32'h0);
        chk("rst_ferr", 32'(frame_err), 32'h0);
        chk("rst_state", 32'(uart_state), 32'h0);
        Rst = 1'b0;
        repeat (10) @(negedge Clk);

        // 1: single good frame at 115200
        d0 = done_cnt; f0 = ferr_cnt;
        send_frame(8'h55, 1'b1, BIT115, -1, -1);
        repeat (20) @(negedge Clk);
        chk("t1_done_cyc", 32'(done_cnt - d0), 32'd1);
        chk("t1_ferr_cyc", 32'(ferr_cnt - f0), 32'd0);
        chk("t1_data", 32'(data_byte), 32'h55);
        chk("t1_log", 32'(rx_log[d0]), 32'h55);

        // 2: back-to-back frames, no idle gap
        d0 = done_cnt;
        send_frame(8'hA3, 1'b1, BIT115, -1, -1);
        send_frame(8'h0F, 1'b1, BIT115, -1, -1);
        repeat (20) @(negedge Clk);
        chk("t2_done_cyc", 32'(done_cnt - d0), 32'd2);
        chk("t2_first", 32'(rx_log[d0]), 32'hA3);
        chk("t2_second", 32'(rx_log[d0 + 1]), 32'h0F);

        // 3a: 100-Clk low glitch: START for 10 ticks (270 Clk) then back to IDLE
        d0 = done_cnt; f0 = ferr_cnt; b0 = busy_cnt;
        Rs232_Rx = 1'b0;
        repeat (100) @(negedge Clk);
        Rs232_Rx = 1'b1;
        repeat (800) @(negedge Clk);
        chk("t3_busy_cyc", 32'(busy_cnt - b0), 32'd270);
        chk("t3_state", 32'(uart_state), 32'h0);
        chk("t3_done_cyc", 32'(done_cnt - d0), 32'd0);
        chk("t3_ferr_cyc", 32'(ferr_cnt - f0), 32'd0);

        // 3b: spike in the middle of data bit 3 of 0x96
        d0 = done_cnt;
        send_frame(8'h96, 1'b1, BIT115, 3, -1);
        repeat (20) @(negedge Clk);
        chk("t3_spk_done", 32'(done_cnt - d0), 32'd1);
        chk("t3_spk_data", 32'(data_byte), 32'h96);

        // 4: good 0x12 then 0xFF with a zero stop bit
        d0 = done_cnt; f0 = ferr_cnt;
        send_frame(8'h12, 1'b1, BIT115, -1, -1);
        send_frame(8'hFF, 1'b0, BIT115, -1, -1);
        repeat (50) @(negedge Clk);
        chk("t4_done_cyc", 32'(done_cnt - d0), 32'd1);
        chk("t4_ferr_cyc", 32'(ferr_cnt - f0), 32'd1);
        chk("t4_data", 32'(data_byte), 32'h12);
        chk("t4_state", 32'(uart_state), 32'h0);

        // 5: asynchronous reset halfway through data bit 4 of 0xA5
        Rs232_Rx = 1'b0;
        repeat (BIT115) @(negedge Clk);
        for (int b = 0; b < 4; b++) begin
            Rs232_Rx = b[0] ? 1'b0 : 1'b1;
            repeat (BIT115) @(negedge Clk);
        end
        Rs232_Rx = 1'b0;
        repeat (BIT115 / 2) @(negedge Clk);
        chk("t5_pre_state", 32'(uart_state), 32'h1);
        #2 Rst = 1'b1;
        #1;
        chk("t5_rst_data", 32'(data_byte), 32'h00);
        chk("t5_rst_state", 32'(uart_state), 32'h0);
        chk("t5_rst_done", 32'(Rx_Done), 32'h0);
        chk("t5_rst_ferr", 32'(frame_err), 32'h0);
        Rs232_Rx = 1'b1;
        repeat (3) @(negedge Clk);
        Rst = 1'b0;
        repeat (20) @(negedge Clk);
        d0 = done_cnt; f0 = ferr_cnt;
        send_frame(8'h3C, 1'b1, BIT115, -1, -1);
        repeat (20) @(negedge Clk);
        chk("t5_done_cyc", 32'(done_cnt - d0), 32'd1);
        chk("t5_ferr_cyc", 32'(ferr_cnt - f0), 32'd0);
        chk("t5_data", 32'(data_byte), 32'h3C);

        // 6: 9600 frame with baud_set moved to 115200 during bit 2
        baud_set = 3'd0;
        repeat (10) @(negedge Clk);
        d0 = done_cnt; f0 = ferr_cnt;
        send_frame(8'hC6, 1'b1, BIT9600, -1, 2);
        repeat (20) @(negedge Clk);
        chk("t6_done_cyc", 32'(done_cnt - d0), 32'd1);
        chk("t6_ferr_cyc", 32'(ferr_cnt - f0), 32'd0);
        chk("t6_data", 32'(data_byte), 32'hC6);

        chk("both_high", 32'(both_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
